// File: rtl/tick_pwm_pkg.sv
// tick_pwm_pkg: shared sizing helpers for the tick/PWM block.
// Used by tick_downcounter and tick_pwm_core.
package tick_pwm_pkg;

  function automatic int max_duty(input int width);
    return (1 << width) - 1;
  endfunction

  function automatic int cnt_width(input int period);
    int c;
    c = $clog2(period);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/tick_downcounter.sv
// tick_downcounter: one-cycle tick every PERIOD enabled clocks.
// Counter reloads to PERIOD-1 and freezes while enable is low.
module tick_downcounter
  import tick_pwm_pkg::*;
#(
  parameter int PERIOD = 392156
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  if (PERIOD < 1) begin : g_bad_period
    $error("tick_downcounter: PERIOD must be >= 1");
  end

  localparam int TW = cnt_width(PERIOD);
  localparam logic [TW-1:0] RELOAD = TW'(PERIOD - 1);

  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;

  assign tick = enable && (tcnt_q == '0);

  always_comb begin
    tcnt_d = tcnt_q;
    if (enable) begin
      if (tcnt_q == '0) tcnt_d = RELOAD;
      else              tcnt_d = tcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tcnt_q <= RELOAD;
    else       tcnt_q <= tcnt_d;
  end

endmodule

// File: rtl/tick_pwm_core.sv
// tick_pwm_core: periodic step tick plus WIDTH-bit PWM generator.
// Define TICK_PWM_DUTY_SHADOW_EN to latch duty only at period start.
module tick_pwm_core
  import tick_pwm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 392156
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_cycle,
  output logic             tick,
  output logic             pwm_out,
  output logic             pwm_period_start
);

  localparam int MAXD = max_duty(WIDTH);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAXD - 1);

  logic [WIDTH-1:0] pcnt_q;
  logic [WIDTH-1:0] pcnt_d;
  logic [WIDTH-1:0] duty_eff;
  logic             pwm_q;
  logic             pwm_d;

  tick_downcounter #(
    .PERIOD(PERIOD)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  assign pwm_period_start = enable && (pcnt_q == '0);

`ifdef TICK_PWM_DUTY_SHADOW_EN
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_d;

  // Period start compares against the value being loaded.
  always_comb begin
    duty_d = duty_q;
    if (pwm_period_start) duty_d = duty_cycle;
  end

  assign duty_eff = duty_d;

  always_ff @(posedge clk) begin
    if (reset) duty_q <= '0;
    else       duty_q <= duty_d;
  end
`else
  assign duty_eff = duty_cycle;
`endif

  always_comb begin
    pcnt_d = pcnt_q;
    if (enable) begin
      if (pcnt_q == LAST) pcnt_d = '0;
      else                pcnt_d = pcnt_q + 1'b1;
    end
  end

  assign pwm_d = enable && (pcnt_q < duty_eff);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_tick_pwm_core.sv
// tb_tick_pwm_core: directed bench, WIDTH=3 PERIOD=5.
// Expected outputs are queued at drive time and checked in-cycle.
module tb_tick_pwm_core;

  localparam int W  = 3;
  localparam int P  = 5;
  localparam int MD = 7;
`ifdef TICK_PWM_DUTY_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] duty_cycle = '0;
  logic         tick;
  logic         pwm_out;
  logic         pwm_period_start;

  tick_pwm_core #(
    .WIDTH (W),
    .PERIOD(P)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .duty_cycle      (duty_cycle),
    .tick            (tick),
    .pwm_out         (pwm_out),
    .pwm_period_start(pwm_period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic tk;
    logic pw;
    logic ps;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  // Model: enabled cycles since reset, registered pwm, shadow duty.
  int   en_cnt = 0;
  logic m_pwm = 1'b0;
  int   m_duty = 0;
  int   hi_cnt;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input int d);
    exp_t e;
    exp_t got;
    int   ph;
    int   dc;
    @(negedge clk);
    reset      = r;
    enable     = en;
    duty_cycle = d[W-1:0];
    ph   = en_cnt % MD;
    e.tk = en && ((en_cnt % P) == P - 1);
    e.ps = en && (ph == 0);
    e.pw = m_pwm;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      got = sb.pop_front();
      chk("tick", tick, got.tk);
      chk("pwm_out", pwm_out, got.pw);
      chk("period_start", pwm_period_start, got.ps);
    end
    if (r) begin
      en_cnt = 0;
      m_pwm  = 1'b0;
      m_duty = 0;
    end else if (en) begin
      dc = d;
      if (SHADOW) begin
        if (ph == 0) m_duty = d;
        dc = m_duty;
      end
      m_pwm = (ph < dc);
      en_cnt++;
    end else begin
      m_pwm = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // reset state
    step(1'b1, 1'b0, 0);
    chk("rst_pwm", pwm_out, 1'b0);
    // tick cadence and period start, duty 3
    for (int k = 1; k <= 21; k++) begin
      step(1'b0, 1'b1, 3);
      chk("tick_cycle", tick, (k % P) == 0);
      chk("ps_cycle", pwm_period_start, ((k - 1) % MD) == 0);
    end
    // duty 3 pattern: 3 highs per period
    hi_cnt = 0;
    for (int k = 0; k < MD; k++) begin
      step(1'b0, 1'b1, 3);
      if (pwm_out === 1'b1) hi_cnt++;
    end
    chk("duty3_hi", hi_cnt == 3, 1'b1);
    // duty 0 then duty MAX
    for (int k = 0; k < 4 * MD; k++) step(1'b0, 1'b1, 0);
    chk("duty0_low", pwm_out, 1'b0);
    for (int k = 0; k < 4 * MD; k++) step(1'b0, 1'b1, 7);
    chk("duty7_high", pwm_out, 1'b1);
    // mid-period duty change 2 -> 5 at pcnt=3
    for (int k = 0; k < MD && (en_cnt % MD) != 0; k++)
      step(1'b0, 1'b1, 2);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2);
    for (int k = 0; k < 2 * MD; k++) step(1'b0, 1'b1, 5);
    // enable gap of 4 at tcnt=2
    for (int k = 0; k < P && (en_cnt % P) != 2; k++)
      step(1'b0, 1'b1, 4);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4);
    chk("gap_pwm", pwm_out, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 4);
    // reset mid-period with duty 6
    for (int k = 0; k < MD && (en_cnt % MD) != 3; k++)
      step(1'b0, 1'b1, 6);
    step(1'b1, 1'b1, 6);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, 6);
      if (k == 1) chk("post_rst_pwm", pwm_out, 1'b0);
      chk("post_rst_tick", tick, (k % P) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
